regwrite_scoreboard_decoder: RTL
================================

Name: regwrite_scoreboard_decoder

Overview:
- Parametrised successor to the CPU's fixed 3:8 write-select decoding: an N-to-2^N one-hot decoder pair (issue and writeback) feeding a registered pending-write scoreboard.
- Sits between decode/issue and the register file.
- Outputs a registered one-hot write-enable vector, per-register busy bits, two read-port hazard flags and an outstanding-write count for the hazard/stall unit.
- The hard-wired zero register (XZR) is never marked busy.

Parameters:
ADDR_W, 5, register address width; NREG = 2**ADDR_W entries
ZERO_REG, 31, index never marked busy or decoded; values >= NREG disable suppression

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
issue_en  input  1  instruction with a register write is issued this cycle
issue_addr  input  ADDR_W  destination register of the issued instruction
wb_en  input  1  writeback of a register write this cycle
wb_addr  input  ADDR_W  register written back
rd_addr_a  input  ADDR_W  source register A to check
rd_addr_b  input  ADDR_W  source register B to check
issue_onehot  output  NREG  registered one-hot decode of the issue address
busy_vec  output  NREG  scoreboard: bit i = write to reg i outstanding
busy_a  output  1  source A has an outstanding write
busy_b  output  1  source B has an outstanding write
pending_cnt  output  ADDR_W+1  number of set bits in busy_vec, registered

Behaviour:
- Reset (synchronous, active-high): issue_onehot, busy_vec and pending_cnt all 0 on the first rising edge with reset=1. Reset dominates issue_en and wb_en on the same edge.
- set_dec = one-hot(issue_addr) when issue_en=1 and issue_addr != ZERO_REG, else all zero. This decode is combinational.
- clr_dec = one-hot(wb_addr) when wb_en=1, else all zero. This decode is combinational.
- issue_onehot <= set_dec. Latency is exactly 1 cycle, and at most one bit is ever set.
- busy_vec <= (busy_vec & ~clr_dec) | set_dec.
- Same-edge set and clear of the same register: set wins, so the bit stays/becomes 1 (a newer write is outstanding).
- Set and clear of different registers on the same edge: both take effect.
- Clear of a non-busy register: no change, no error.
- Set of an already-busy register: stays 1. There is no per-register counting; a single outstanding write per register is the pipeline contract.
- busy_vec[ZERO_REG] is always 0.
- pending_cnt <= popcount of the next busy_vec value, so it always equals popcount(busy_vec) in the same cycle. Maximum is NREG-1 when ZERO_REG < NREG, else NREG; the width ADDR_W+1 never overflows.
- busy_a = busy_vec[rd_addr_a] and busy_b = busy_vec[rd_addr_b]. Both are combinational from current state.
- rd_addr equal to ZERO_REG always gives busy 0.
- Same-cycle issue does not affect busy_a/busy_b until the next cycle.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined:
  - busy_a = busy_vec[rd_addr_a] & ~(wb_en & (wb_addr == rd_addr_a)); busy_b likewise.
  - A source written back this cycle is reported not busy, because the register file forwards the writeback value.
  - busy_vec and pending_cnt are unaffected.
- Undefined: busy_a/busy_b reflect registered state only; a writeback clears busy one cycle later.

Test Plan:
- Reset: hold reset=1 for 2 edges with issue_en=1, issue_addr=3 -> issue_onehot=0, busy_vec=0, pending_cnt=0.
- Decode sweep: issue_en=1, issue_addr=0..30 on successive cycles.
  - Each cycle: issue_onehot = 1<<addr, one cycle late.
  - Final result: busy_vec=32'h7FFF_FFFF, pending_cnt=31.
- Zero register: issue_en=1, issue_addr=31 -> issue_onehot=0, busy_vec[31]=0, pending_cnt unchanged. Also rd_addr_a=31 -> busy_a=0.
- Hazard and clear:
  - Issue to reg 5, then rd_addr_a=5 -> busy_a=1 next cycle.
  - wb_en=1, wb_addr=5 -> busy_a=0 after the edge (without the macro); busy_a=0 in the same cycle (with SCOREBOARD_WB_BYPASS_EN).
- Simultaneous: busy_vec[7]=1, then issue_addr=7 and wb_addr=7 on the same edge -> busy_vec[7]=1, pending_cnt unchanged.
  - Same with issue_addr=8, wb_addr=7 -> bit7=0, bit8=1, count unchanged.
- Reset mid-operation: with pending_cnt=10, assert reset for one edge together with issue_en=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/regwrite_scoreboard_decoder.sv
// Issue/writeback one-hot decoders feeding a registered pending-write scoreboard.
// Optional macro SCOREBOARD_WB_BYPASS_EN: a same-cycle writeback masks the read-port busy flags.
module regwrite_scoreboard_decoder #(
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_en,
    input  logic [ADDR_W-1:0]      issue_addr,
    input  logic                   wb_en,
    input  logic [ADDR_W-1:0]      wb_addr,
    input  logic [ADDR_W-1:0]      rd_addr_a,
    input  logic [ADDR_W-1:0]      rd_addr_b,
    output logic [2**ADDR_W-1:0]   issue_onehot,
    output logic [2**ADDR_W-1:0]   busy_vec,
    output logic                   busy_a,
    output logic                   busy_b,
    output logic [ADDR_W:0]        pending_cnt
);
    localparam int NREG    = 2**ADDR_W;
    // Out-of-range ZERO_REG turns suppression off entirely.
    localparam bit ZERO_EN = (ZERO_REG >= 0) && (ZERO_REG < NREG);

    logic            issue_zero;
    logic [NREG-1:0] set_dec;
    logic [NREG-1:0] clr_dec;
    logic [NREG-1:0] busy_nxt;
    logic [ADDR_W:0] cnt_nxt;

    assign issue_zero = ZERO_EN && (int'(issue_addr) == ZERO_REG);

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        assign set_dec[i] = issue_en && !issue_zero && (issue_addr == ADDR_W'(i));
        assign clr_dec[i] = wb_en && (wb_addr == ADDR_W'(i));
    end

    // Set is applied after clear so a newer issue survives a same-edge writeback.
    assign busy_nxt = (busy_vec & ~clr_dec) | set_dec;

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_onehot <= '0;
            busy_vec     <= '0;
            pending_cnt  <= '0;
        end else begin
            issue_onehot <= set_dec;
            busy_vec     <= busy_nxt;
            pending_cnt  <= cnt_nxt;
        end
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    // The register file forwards the writeback value, so that source is not a hazard.
    assign busy_a = busy_vec[rd_addr_a] & ~(wb_en & (wb_addr == rd_addr_a));
    assign busy_b = busy_vec[rd_addr_b] & ~(wb_en & (wb_addr == rd_addr_b));
`else
    assign busy_a = busy_vec[rd_addr_a];
    assign busy_b = busy_vec[rd_addr_b];
`endif
endmodule
